fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of decode.
- Holds the program counter and issues word requests to instruction memory over a req/gnt + rvalid interface.
- Buffers returned words with their PC in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch entry type passed from fetch to decode.
package cpu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Sequential word address; wraps modulo 2^32.
   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through FIFO with synchronous clear; push and pop may coincide when full.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                       clk_i,
   input  logic                       res_i,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       empty_o,
   output logic                       full_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees the slot first, so a full FIFO still accepts a simultaneous push.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (res_i || clr_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, stale-response dropping on
// redirect, and an FWFT buffer feeding decode.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk_i,
   input  logic               res_i,
   output logic               imem_req_o,
   output logic [XLEN-1:0]    imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   input  logic               redirect_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [XLEN-1:0]    instr_pc_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   credit_used;
   logic [XLEN-1:0]  redirect_target;
   logic             empty, full, grant, push, pop, clr;
   fetch_entry_t     push_entry, head;

   // Buffered plus in-flight words may never exceed the FIFO size, so a push never overflows.
   assign credit_used = {1'b0, count} + {1'b0, outstanding_q};
   assign imem_req_o  = !res_i && !redirect_i && (credit_used < (CNT_W + 1)'(DEPTH));
   assign imem_addr_o = fetch_pc_q;
   assign grant       = imem_req_o && imem_gnt_i;

   assign redirect_target = redirect_pc_i & ~XLEN'(3);
   assign push_entry      = '{pc: resp_pc_q, instr: imem_rdata_i};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      push          = 1'b0;
      pop           = 1'b0;
      clr           = 1'b0;
      if (redirect_i) begin
         // Every fetch still in flight after this cycle belongs to the old path.
         fetch_pc_d    = redirect_target;
         resp_pc_d     = redirect_target;
         clr           = 1'b1;
         outstanding_d = outstanding_q - CNT_W'(imem_rvalid_i);
         drop_cnt_d    = outstanding_d;
      end else begin
         pop           = instr_valid_o && instr_ready_i;
         outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
         if (grant) fetch_pc_d = pc_next(fetch_pc_q);
         if (imem_rvalid_i) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = pc_next(resp_pc_q);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH),
      .WIDTH($bits(fetch_entry_t))
   ) u_fifo (
      .clk_i  (clk_i),
      .res_i  (res_i),
      .clr_i  (clr),
      .push_i (push),
      .wdata_i(push_entry),
      .pop_i  (pop),
      .rdata_o(head),
      .count_o(count),
      .empty_o(empty),
      .full_o (full)
   );

   assign instr_valid_o = !empty;
   assign instr_o       = empty ? '0 : head.instr;
   assign instr_pc_o    = empty ? '0 : head.pc;

   always_ff @(posedge clk_i) begin
      if (!res_i) begin
         assert (!(push && full && !pop));
         assert (drop_cnt_q <= outstanding_q);
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: grants push expected {pc, word}, redirect/reset flush them,
// and every accepted output is compared against the queue head.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        res, redirect, instr_ready, gnt_en;
   logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
   logic        w_req, w_rvalid, w_valid;
   logic [31:0] w_addr, w_rdata, w_instr, w_instr_pc;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          lat      = 1;
   int          grant_cnt = 0;
   logic [31:0] mem_addr_q[$];
   int          mem_due_q[$];
   logic [63:0] sb_q[$];
   logic        w_pend_v = 1'b0;
   logic [31:0] w_pend_addr = '0;

   always #5 clk = ~clk;
   assign imem_gnt = gnt_en;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
      .clk_i(clk), .res_i(res), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .instr_valid_o(instr_valid),
      .instr_ready_i(instr_ready), .instr_o(instr), .instr_pc_o(instr_pc)
   );

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk_i(clk), .res_i(res), .imem_req_o(w_req), .imem_addr_o(w_addr),
      .imem_gnt_i(1'b1), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
      .redirect_i(1'b0), .redirect_pc_i(32'h0), .instr_valid_o(w_valid),
      .instr_ready_i(1'b1), .instr_o(w_instr), .instr_pc_o(w_instr_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic peek();
      #2;
   endtask

   task automatic do_reset();
      res      = 1'b1;
      redirect = 1'b0;
      step(2);
      res = 1'b0;
   endtask

   // Memory response drive: in-order, each word due lat cycles after its grant.
   always @(negedge clk) begin
      imem_rvalid = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
      imem_rdata  = imem_rvalid ? mem_word(mem_addr_q[0]) : 32'h0;
      w_rvalid    = w_pend_v;
      w_rdata     = mem_word(w_pend_addr);
   end

   // Sample point late in each cycle; the following rising edge acts on these values.
   always @(negedge clk) begin
      logic [31:0] a;
      int          d;
      logic [63:0] e;
      #3;
      cyc++;
      if (res) begin
         mem_addr_q.delete();
         mem_due_q.delete();
         sb_q.delete();
         w_pend_v  = 1'b0;
         grant_cnt = 0;
      end else begin
         if (imem_rvalid) begin
            a = mem_addr_q.pop_front();
            d = mem_due_q.pop_front();
         end
         if (redirect) begin
            check("req_in_redirect", 32'(imem_req), 32'h0);
            sb_q.delete();
         end
         if (imem_req && imem_gnt) begin
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(cyc + lat - 1);
            sb_q.push_back({imem_addr, mem_word(imem_addr)});
            grant_cnt++;
         end
         if (instr_valid && instr_ready && !redirect) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'h1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("out_pc", instr_pc, e[63:32]);
               check("out_instr", instr, e[31:0]);
            end
         end
         w_pend_v    = w_req;
         w_pend_addr = w_addr;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_valid;
      int found;
      res = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; gnt_en = 1'b0;

      // Reset state
      step(3);
      peek();
      check("rst_req", 32'(imem_req), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", instr_pc, 32'h0);

      // Streaming, first-output latency, and PC wrap on the second instance
      step();
      res = 1'b0; gnt_en = 1'b1; instr_ready = 1'b1; lat = 1;
      first_valid = 0;
      for (int k = 1; k <= 6; k++) begin
         peek();
         if (first_valid == 0 && instr_valid) first_valid = k;
         if (k <= 3) begin
            check("wrap_req", 32'(w_req), 32'h1);
            check("wrap_addr", w_addr, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
         end
         if (k >= 3 && k <= 5) begin
            check("wrap_valid", 32'(w_valid), 32'h1);
            check("wrap_pc", w_instr_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 3)));
            check("wrap_instr", w_instr, mem_word(32'hFFFF_FFF8 + 32'(4 * (k - 3))));
         end
         step();
      end
      check("first_valid_cycle", 32'(first_valid), 32'd3);
      step(4);

      // Back-pressure: credits cap grants at DEPTH
      instr_ready = 1'b0; gnt_en = 1'b1; lat = 1;
      do_reset();
      step(10);
      peek();
      check("bp_grants", 32'(grant_cnt), 32'd4);
      check("bp_req", 32'(imem_req), 32'h0);
      check("bp_valid", 32'(instr_valid), 32'h1);
      check("bp_head_pc", instr_pc, 32'h0);
      step();
      instr_ready = 1'b1;
      step();
      peek();
      check("bp_resume_req", 32'(imem_req), 32'h1);
      step(8);

      // Redirect with two fetches in flight
      instr_ready = 1'b1; gnt_en = 1'b1; lat = 3;
      do_reset();
      step(2);
      gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
      peek();
      check("rd_outstanding", 32'(u_dut.outstanding_q), 32'd2);
      step();
      redirect = 1'b0; gnt_en = 1'b1;
      peek();
      check("rd_req", 32'(imem_req), 32'h1);
      check("rd_addr", imem_addr, 32'h0000_0100);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (instr_valid) begin
            found = 1;
            break;
         end
         step();
         peek();
      end
      check("rd_output_seen", 32'(found), 32'h1);
      check("rd_first_pc", instr_pc, 32'h0000_0100);
      step(8);

      // Redirect coinciding with a response and a pop; new target exercises PC wrap
      instr_ready = 1'b1; gnt_en = 1'b1; lat = 2;
      do_reset();
      step(8);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
      peek();
      check("rp_rvalid", 32'(imem_rvalid), 32'h1);
      check("rp_valid", 32'(instr_valid), 32'h1);
      check("rp_outstanding", 32'(u_dut.outstanding_q), 32'd2);
      step();
      redirect = 1'b0;
      peek();
      check("rp_empty", 32'(instr_valid), 32'h0);
      check("rp_drop_cnt", 32'(u_dut.drop_cnt_q), 32'd1);
      check("rp_addr", imem_addr, 32'hFFFF_FFF8);
      step(12);

      // Reset with 3 buffered and 1 outstanding
      instr_ready = 1'b0; gnt_en = 1'b1; lat = 2;
      do_reset();
      found = 0;
      for (int k = 0; k < 20; k++) begin
         peek();
         if (u_dut.count == 3 && u_dut.outstanding_q == 1) begin
            found = 1;
            break;
         end
         step();
      end
      check("mr_precondition", 32'(found), 32'h1);
      res = 1'b1;
      step();
      res = 1'b0; instr_ready = 1'b1; lat = 1;
      peek();
      check("mr_valid", 32'(instr_valid), 32'h0);
      check("mr_req", 32'(imem_req), 32'h1);
      check("mr_addr", imem_addr, 32'h0);
      step(8);

      // Drain: every expected word must have come out
      gnt_en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (sb_q.size() == 0) break;
         step();
      end
      step(2);
      check("drain_sb_empty", 32'(sb_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
